cache_ri_ctrl: RTL

//  Refill/IO sequencer behind the data cache read/write front end. Takes one command at a time on the
//  m0_cmd valid/ready channel and runs it: 4-word line refill from memory into the cache RAMs, one

---
 rtl/cache_ri_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ri_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ri_ctrl
// Purpose  : Refill/IO sequencer behind the data cache front end. Accepts one
//            command at a time and runs it to completion:
//              - 4-word line refill from memory into the cache data/tag RAMs
//              - a single uncached IO read or write
//              - an invalidate sweep over every cache line
//            Owns the Avalon-style memory master port m1.
// Ports    : clk, rest             clock, synchronous active-high reset
//            m0_cmd*               command channel (ready = 1-cycle done pulse)
//            req_*                 fields of the pending access
//            io_readData*          IO read result + strobe
//            rf_*                  data RAM word write / tag-valid write
//            m1_*                  memory master (pipelined reads, waitRequest)
// Revision : 1.0  initial release
// ============================================================================
module cache_ri_ctrl #(
  parameter int         IDX_W    = 7,
  parameter logic [3:0] CMD_RB   = 4'd1,
  parameter logic [3:0] CMD_IORW = 4'd2,
  parameter logic [3:0] CMD_CTRL = 4'd3
) (
  input  logic              clk,
  input  logic              rest,
  // command channel
  input  logic [3:0]        m0_cmd,
  input  logic              m0_cmd_valid,
  output logic              m0_cmd_ready,
  // pending access
  input  logic [31:0]       req_address,
  input  logic [3:0]        req_byteEnable,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_writeData,
  // IO read result
  output logic [31:0]       io_readData,
  output logic              io_readDataValid,
  // cache RAM write side
  output logic [IDX_W+1:0]  rf_wAddr,
  output logic [31:0]       rf_wData,
  output logic              rf_wEn,
  output logic              rf_tagWrite,
  output logic              rf_tagValid,
  // memory master
  output logic [31:0]       m1_address,
  output logic [3:0]        m1_byteEnable,
  output logic              m1_read,
  output logic              m1_write,
  output logic [31:0]       m1_writeData,
  input  logic [31:0]       m1_readData,
  input  logic              m1_waitRequest,
  input  logic              m1_readDataValid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RB_REQ  = 3'd1,
    S_RB_WAIT = 3'd2,
    S_IO_REQ  = 3'd3,
    S_IO_WAIT = 3'd4,
    S_INV     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] c_LINE_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] c_LINE_LAST = '1;

  state_t            r_state;
  state_t            w_next;

  // Latched request; the byte offset is irrelevant since every bus access is
  // word aligned, so only bits [31:2] are kept.
  logic [31:2]       r_addr;
  logic [3:0]        r_be;
  logic              r_rd;
  logic              r_wr;
  logic [31:0]       r_wdata;

  logic [1:0]        r_issue_cnt;   // refill reads accepted by memory
  logic [1:0]        r_rcv_cnt;     // refill words returned
  logic [IDX_W-1:0]  r_line;        // invalidate sweep line

  logic              w_rb_accept;   // refill read accepted this cycle
  logic              w_rb_data;     // refill word returned this cycle
  logic              w_rb_last;     // 4th refill word returned this cycle
  logic              w_unused;

  assign w_unused    = ^req_address[1:0];

  assign w_rb_accept = (r_state == S_RB_REQ) && !m1_waitRequest;
  // Data may still be arriving while the last reads are being issued, so
  // both refill states accept returning words.
  assign w_rb_data   = ((r_state == S_RB_REQ) || (r_state == S_RB_WAIT)) && m1_readDataValid;
  assign w_rb_last   = w_rb_data && (r_rcv_cnt == 2'd3);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_be        <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
      r_line      <= '0;
    end else begin
      r_state <= w_next;

      if ((r_state == S_IDLE) && m0_cmd_valid) begin
        r_addr      <= req_address[31:2];
        r_be        <= req_byteEnable;
        r_rd        <= req_read;
        r_wr        <= req_write;
        r_wdata     <= req_writeData;
        r_issue_cnt <= '0;
        r_rcv_cnt   <= '0;
        r_line      <= '0;
      end else begin
        if (w_rb_accept) begin
          r_issue_cnt <= r_issue_cnt + 2'd1;
        end
        if (w_rb_data) begin
          r_rcv_cnt <= r_rcv_cnt + 2'd1;
        end
        // Wraps back to 0 after the last line so the next sweep starts clean.
        if (r_state == S_INV) begin
          r_line <= r_line + c_LINE_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next           = r_state;
    m0_cmd_ready     = 1'b0;
    io_readData      = '0;
    io_readDataValid = 1'b0;
    rf_wAddr         = '0;
    rf_wData         = '0;
    rf_wEn           = 1'b0;
    rf_tagWrite      = 1'b0;
    rf_tagValid      = 1'b0;
    m1_address       = '0;
    m1_byteEnable    = '0;
    m1_read          = 1'b0;
    m1_write         = 1'b0;
    m1_writeData     = '0;

    // Refill data return is shared by both refill states.
    if (w_rb_data) begin
      rf_wEn   = 1'b1;
      rf_wData = m1_readData;
      rf_wAddr = {r_addr[IDX_W+3:4], r_rcv_cnt};
      if (w_rb_last) begin
        rf_tagWrite = 1'b1;
        rf_tagValid = 1'b1;
      end
    end

    unique case (r_state)
      S_IDLE: begin
        if (m0_cmd_valid) begin
          if (m0_cmd == CMD_RB) begin
            w_next = S_RB_REQ;
          end else if (m0_cmd == CMD_IORW) begin
            w_next = S_IO_REQ;
          end else if (m0_cmd == CMD_CTRL) begin
            w_next = S_INV;
          end else begin
            w_next = S_DONE;
          end
        end
      end

      S_RB_REQ: begin
        m1_read       = 1'b1;
        m1_address    = {r_addr[31:4], r_issue_cnt, 2'b00};
        m1_byteEnable = 4'hF;
        if (w_rb_last) begin
          w_next = S_DONE;
        end else if (w_rb_accept && (r_issue_cnt == 2'd3)) begin
          w_next = S_RB_WAIT;
        end
      end

      S_RB_WAIT: begin
        if (w_rb_last) begin
          w_next = S_DONE;
        end
      end

      S_IO_REQ: begin
        m1_address    = {r_addr[31:2], 2'b00};
        m1_byteEnable = r_be;
        m1_writeData  = r_wdata;
        // A request flagged as both read and write is performed as a read.
        m1_read       = r_rd;
        m1_write      = r_wr && !r_rd;
        if (!r_rd && !r_wr) begin
          w_next = S_DONE;
        end else if (!m1_waitRequest) begin
          w_next = r_rd ? S_IO_WAIT : S_DONE;
        end
      end

      S_IO_WAIT: begin
        if (m1_readDataValid) begin
          io_readData      = m1_readData;
          io_readDataValid = 1'b1;
          w_next           = S_DONE;
        end
      end

      S_INV: begin
        rf_tagWrite = 1'b1;
        rf_tagValid = 1'b0;
        rf_wAddr    = {r_line, 2'b00};
        if (r_line == c_LINE_LAST) begin
          w_next = S_DONE;
        end
      end

      S_DONE: begin
        m0_cmd_ready = 1'b1;
        w_next       = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
